hub75_scan_ctrl: RTL
====================

Name: hub75_scan_ctrl

Overview:
- Read side of the HUB75 frame buffer. Fetches pixel pairs through the buffer's read port (top half row r, bottom half row r+vpixel_p/2).
- Slices out one bit plane and serialises it onto the panel RGB lines.
- Latches each row and drives OE with binary-coded-modulation weighting.
- Sits between hub75_framebuf (read port) and the HUB75 pins inside hub75_driver.

Parameters:
hpixel_p, 64, display width in pixels
vpixel_p, 64, display height in pixels (even; rows scanned = vpixel_p/2)
bpp_p, 8, bits per colour channel = number of bit planes
bcm_base_p, 4, OE-active clk cycles for plane 0; plane b lasts bcm_base_p<<b
addr_width_p, $clog2(hpixel_p*vpixel_p), frame-buffer address width (localparam)
row_width_p, $clog2(vpixel_p/2), row counter width (localparam)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
i_en  in  1  scan enable; level-sensitive
o_rd_addr  out  addr_width_p  frame-buffer read address, y*hpixel_p+x
i_rd_data  in  3*bpp_p  read data {R,G,B}, valid one clk after o_rd_addr
o_frame_done  out  1  one-cycle pulse when the last plane of the last row completes
O_CLK  out  1  panel shift clock
STB  out  1  panel latch strobe, active high
OE  out  1  panel output enable, active low (1 = blanked)
A,B,C,D,E  out  1 each  row select, {E,D,C,B,A} = displayed row; bits above row_width_p tied 0
R1,G1,B1  out  1 each  top-half colour bit
R2,G2,B2  out  1 each  bottom-half colour bit

Behaviour:
- Clocking and reset:
  - All outputs registered.
  - rst=1 at any clk edge, including mid-shift or mid-display: state=IDLE, col/row/plane=0. Next cycle O_CLK=0, STB=0, OE=1, A..E=0, RGB=0, o_rd_addr=0, o_frame_done=0.
- States: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: OE=1, O_CLK=0, STB=0. i_en=1 -> SHIFT with col=0 (row and plane hold their values; 0 after reset).
- SHIFT: 5 phases per column, so 5*hpixel_p clks per plane.
  - P0: o_rd_addr = row*hpixel_p + col.
  - P1: o_rd_addr = (row+vpixel_p/2)*hpixel_p + col; top pixel captured at end of P1.
  - P2: bottom pixel taken from i_rd_data. At end of P2, R1/G1/B1 and R2/G2/B2 are loaded with bit [plane] of each channel.
  - Channel fields: R = [3bpp-1:2bpp], G = [2bpp-1:bpp], B = [bpp-1:0].
  - P3: O_CLK=0, RGB stable.
  - P4: O_CLK=1; the panel samples on this rising edge. RGB holds until end of P2 of the next column.
  - After P4 of col hpixel_p-1 -> LATCH.
  - OE=1 throughout SHIFT. Display is not overlapped with shifting.
- LATCH: exactly 1 clk.
  - STB=1, OE=1, O_CLK=0.
  - {E,D,C,B,A} <= row on entry, so the address changes only while blanked.
  - -> DISPLAY.
- DISPLAY:
  - OE=0 for exactly bcm_base_p<<plane clks; counter width $clog2(bcm_base_p<<(bpp_p-1))+1.
  - On final cycle: OE returns to 1 next cycle.
  - If plane<bpp_p-1: plane++.
  - Else: plane=0; row++ (wraps from vpixel_p/2-1 to 0). On wrap, o_frame_done=1 for one cycle, coincident with OE going to 1.
  - Then: i_en=1 -> SHIFT col=0; i_en=0 -> IDLE.
- i_en deasserted mid-SHIFT/LATCH/DISPLAY: the current plane completes (shift, latch, full display) before IDLE. Re-enable resumes at the next plane/row.
- No backpressure on the read port; the frame buffer always answers with 1-cycle latency. Writes during scan may tear; this is acceptable.
- Per-plane period: 5*hpixel_p + 1 + (bcm_base_p<<plane) clks.

Test Plan:
1. Reset: assert rst mid-DISPLAY (OE=0) -> next cycle OE=1, STB=0, O_CLK=0, A..E=0, RGB=0; with i_en=0 all outputs hold.
2. Address sequence, hpixel_p=4, vpixel_p=4: enable -> o_rd_addr on P0/P1 phases = 0,8,1,9,2,10,3,11. Then 4 O_CLK rising edges, each 5 clks apart, then one STB pulse with A=0.
3. Bit slicing, bpp_p=8: pixel(0,0)=24'hFF0080, pixel(0,2)=24'h00FF01.
   - Plane 0: R1=1 G1=0 B1=0, R2=0 G2=1 B2=1.
   - Plane 7: R1=1 G1=0 B1=1, R2=0 G2=1 B2=0.
   - All values stable across the O_CLK rising edge.
4. BCM weighting, bcm_base_p=2, bpp_p=8: OE low widths for planes 0..7 = 2,4,8,16,32,64,128,256 clks. Each is preceded by a 1-clk STB with OE=1, and each plane period = 5*hpixel_p+1+width.
5. Frame wrap, vpixel_p=4 (2 rows): after row 1 plane 7 -> o_frame_done single pulse; next LATCH drives A=0, o_rd_addr restarts at 0.
6. i_en dropped during SHIFT of row 0 plane 3 -> plane 3 fully shifted, latched, displayed for bcm_base_p*8 clks, then IDLE (OE=1). Re-enable -> shifting of plane 4 starts at o_rd_addr=0.

Source files
------------

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: reads top/bottom pixel pairs from the frame buffer,
// shifts one bit plane per pass onto the panel and displays it with BCM-weighted OE.
module hub75_scan_ctrl #(
  parameter int unsigned hpixel_p   = 64,
  parameter int unsigned vpixel_p   = 64,
  parameter int unsigned bpp_p      = 8,
  parameter int unsigned bcm_base_p = 4,
  localparam int unsigned addr_width_p = $clog2(hpixel_p*vpixel_p),
  localparam int unsigned row_width_p  = $clog2(vpixel_p/2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  output logic [addr_width_p-1:0] o_rd_addr,
  input  logic [3*bpp_p-1:0]      i_rd_data,
  output logic                    o_frame_done,
  output logic                    O_CLK,
  output logic                    STB,
  output logic                    OE,
  output logic                    A,
  output logic                    B,
  output logic                    C,
  output logic                    D,
  output logic                    E,
  output logic                    R1,
  output logic                    G1,
  output logic                    B1,
  output logic                    R2,
  output logic                    G2,
  output logic                    B2
);

  localparam int unsigned rows_lp       = vpixel_p / 2;
  localparam int unsigned row_bits_lp   = (row_width_p > 0) ? row_width_p : 1;
  localparam int unsigned col_bits_lp   = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int unsigned plane_bits_lp = (bpp_p > 1) ? $clog2(bpp_p) : 1;
  localparam int unsigned cnt_bits_lp   = $clog2(bcm_base_p << (bpp_p-1)) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  state_t                   r_state;
  logic [2:0]               r_phase;
  logic [col_bits_lp-1:0]   r_col;
  logic [row_bits_lp-1:0]   r_row;
  logic [plane_bits_lp-1:0] r_plane;
  logic [cnt_bits_lp-1:0]   r_cnt;
  logic [3*bpp_p-1:0]       r_top;
  logic [addr_width_p-1:0]  r_addr;
  logic                     r_frame_done;
  logic                     r_oclk;
  logic                     r_stb;
  logic                     r_oe;
  logic [4:0]               r_rowsel;
  logic [5:0]               r_rgb;

  logic                     w_last_plane;
  logic                     w_last_row;
  logic                     w_last_col;
  logic [plane_bits_lp-1:0] w_next_plane;
  logic [row_bits_lp-1:0]   w_next_row;
  logic [cnt_bits_lp-1:0]   w_bcm_len;
  logic [bpp_p-1:0]         w_tr, w_tg, w_tb, w_br, w_bg, w_bb;

  function automatic logic [addr_width_p-1:0] f_addr(
    input logic [row_bits_lp-1:0] row,
    input logic [col_bits_lp-1:0] col,
    input logic                   bottom
  );
    logic [addr_width_p-1:0] y;
    y = addr_width_p'(row) + (bottom ? addr_width_p'(rows_lp) : '0);
    return y * addr_width_p'(hpixel_p) + addr_width_p'(col);
  endfunction

  assign w_tr = r_top[3*bpp_p-1 -: bpp_p];
  assign w_tg = r_top[2*bpp_p-1 -: bpp_p];
  assign w_tb = r_top[bpp_p-1:0];
  assign w_br = i_rd_data[3*bpp_p-1 -: bpp_p];
  assign w_bg = i_rd_data[2*bpp_p-1 -: bpp_p];
  assign w_bb = i_rd_data[bpp_p-1:0];

  always_comb begin
    w_last_plane = (r_plane == plane_bits_lp'(bpp_p-1));
    w_last_row   = (r_row == row_bits_lp'(rows_lp-1));
    w_last_col   = (r_col == col_bits_lp'(hpixel_p-1));
    w_next_plane = w_last_plane ? '0 : r_plane + plane_bits_lp'(1);
    w_next_row   = r_row;
    if (w_last_plane) begin
      w_next_row = w_last_row ? '0 : r_row + row_bits_lp'(1);
    end
    // Counter is loaded with length-1 so OE stays low for exactly the plane weight.
    w_bcm_len = (cnt_bits_lp'(bcm_base_p) << r_plane) - cnt_bits_lp'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_plane      <= '0;
      r_cnt        <= '0;
      r_top        <= '0;
      r_addr       <= '0;
      r_frame_done <= 1'b0;
      r_oclk       <= 1'b0;
      r_stb        <= 1'b0;
      r_oe         <= 1'b1;
      r_rowsel     <= '0;
      r_rgb        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_oe   <= 1'b1;
          r_oclk <= 1'b0;
          r_stb  <= 1'b0;
          if (i_en) begin
            r_state <= S_SHIFT;
            r_phase <= 3'd0;
            r_col   <= '0;
            r_addr  <= f_addr(r_row, '0, 1'b0);
          end
        end
        S_SHIFT: begin
          unique case (r_phase)
            3'd0: begin
              r_addr  <= f_addr(r_row, r_col, 1'b1);
              r_phase <= 3'd1;
            end
            3'd1: begin
              r_top   <= i_rd_data;
              r_phase <= 3'd2;
            end
            3'd2: begin
              r_rgb   <= {w_tr[r_plane], w_tg[r_plane], w_tb[r_plane],
                          w_br[r_plane], w_bg[r_plane], w_bb[r_plane]};
              r_phase <= 3'd3;
            end
            3'd3: begin
              r_oclk  <= 1'b1;
              r_phase <= 3'd4;
            end
            default: begin
              r_oclk <= 1'b0;
              if (w_last_col) begin
                r_state  <= S_LATCH;
                r_stb    <= 1'b1;
                r_rowsel <= 5'(r_row);
              end else begin
                r_col   <= r_col + col_bits_lp'(1);
                r_phase <= 3'd0;
                r_addr  <= f_addr(r_row, r_col + col_bits_lp'(1), 1'b0);
              end
            end
          endcase
        end
        S_LATCH: begin
          r_stb   <= 1'b0;
          r_oe    <= 1'b0;
          r_cnt   <= w_bcm_len;
          r_state <= S_DISPLAY;
        end
        S_DISPLAY: begin
          if (r_cnt == '0) begin
            r_oe    <= 1'b1;
            r_plane <= w_next_plane;
            r_row   <= w_next_row;
            if (w_last_plane && w_last_row) begin
              r_frame_done <= 1'b1;
            end
            // Enable is only sampled here, so a plane always runs to completion.
            if (i_en) begin
              r_state <= S_SHIFT;
              r_phase <= 3'd0;
              r_col   <= '0;
              r_addr  <= f_addr(w_next_row, '0, 1'b0);
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - cnt_bits_lp'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_addr    = r_addr;
  assign o_frame_done = r_frame_done;
  assign O_CLK        = r_oclk;
  assign STB          = r_stb;
  assign OE           = r_oe;
  assign {E, D, C, B, A} = r_rowsel;
  assign {R1, G1, B1, R2, G2, B2} = r_rgb;

endmodule
